// File: rtl/logicunit_bist_pkg.sv
// rtl/logicunit_bist_pkg.sv - shared state encodings, opcodes and vector constants for the logic-unit BIST
package logicunit_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } bist_state_t;

    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_NOR = 2'd2;
    localparam logic [1:0] OP_XOR = 2'd3;

    localparam logic [3:0] IDX_FIRST = 4'd0;
    localparam logic [3:0] IDX_LAST  = 4'd15;

endpackage

// File: rtl/logicunit_bist_if.sv
// rtl/logicunit_bist_if.sv - BIST control/status and logic-unit operand bundle
interface logicunit_bist_if #(
    parameter int ERR_W = 5
);
    logic             start;
    logic             dut_a;
    logic             dut_b;
    logic [1:0]       dut_control;
    logic             dut_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic             fail_valid;
    logic [3:0]       first_fail;

    // master is the BIST engine; slave is the host plus the unit under test
    modport master (
        input  start, dut_out,
        output dut_a, dut_b, dut_control, busy, done, pass,
               err_count, fail_valid, first_fail
    );

    modport slave (
        output start, dut_out,
        input  dut_a, dut_b, dut_control, busy, done, pass,
               err_count, fail_valid, first_fail
    );
endinterface

// File: rtl/logicunit_bist_expect.sv
// rtl/logicunit_bist_expect.sv - golden combinational result of the logic unit for one vector
module logicunit_expect
    import logicunit_bist_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [1:0] control,
    output logic       expected
);

    always_comb begin
        expected = 1'b0;
        case (control)
            OP_AND:  expected = a & b;
            OP_OR:   expected = a | b;
            OP_NOR:  expected = ~(a | b);
            OP_XOR:  expected = a ^ b;
            default: expected = 1'b0;
        endcase
    end

endmodule

// File: rtl/logicunit_bist.sv
// rtl/logicunit_bist.sv - exhaustive 16-vector self test of a 2-input, 4-opcode logic unit
module logicunit_bist
    import logicunit_bist_pkg::*;
#(
    parameter int ERR_W = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    logicunit_bist_if.master     bus
);

    bist_state_t      r_state;
    bist_state_t      w_state_nxt;
    logic [3:0]       r_idx;
    logic [3:0]       w_idx_nxt;
    logic [ERR_W-1:0] r_err_count;
    logic [ERR_W-1:0] w_err_count_nxt;
    logic             r_fail_valid;
    logic             w_fail_valid_nxt;
    logic [3:0]       r_first_fail;
    logic [3:0]       w_first_fail_nxt;
    logic             w_expected;
    logic             w_mismatch;

    // The operands are the index itself, so the driven vector always equals r_idx
    logicunit_expect u_expect (
        .a        (r_idx[0]),
        .b        (r_idx[1]),
        .control  (r_idx[3:2]),
        .expected (w_expected)
    );

    assign w_mismatch = (bus.dut_out != w_expected);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_idx        <= IDX_FIRST;
            r_err_count  <= '0;
            r_fail_valid <= 1'b0;
            r_first_fail <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_err_count  <= w_err_count_nxt;
            r_fail_valid <= w_fail_valid_nxt;
            r_first_fail <= w_first_fail_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_err_count_nxt  = r_err_count;
        w_fail_valid_nxt = r_fail_valid;
        w_first_fail_nxt = r_first_fail;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_state_nxt      = ST_RUN;
                    w_idx_nxt        = IDX_FIRST;
                    w_err_count_nxt  = '0;
                    w_fail_valid_nxt = 1'b0;
                    w_first_fail_nxt = 4'd0;
                end
            end
            ST_RUN: begin
                if (w_mismatch) begin
                    // At most 16 mismatches per pass, so an ERR_W >= 5 counter cannot wrap
                    w_err_count_nxt = r_err_count + {{(ERR_W-1){1'b0}}, 1'b1};
                    if (!r_fail_valid) begin
                        w_fail_valid_nxt = 1'b1;
                        w_first_fail_nxt = r_idx;
                    end
                end
                if (r_idx == IDX_LAST) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_idx_nxt = r_idx + 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.dut_a       = r_idx[0];
    assign bus.dut_b       = r_idx[1];
    assign bus.dut_control = r_idx[3:2];
    assign bus.busy        = (r_state == ST_RUN);
    assign bus.done        = (r_state == ST_DONE);
    assign bus.pass        = (r_state == ST_DONE) && (r_err_count == '0);
    assign bus.err_count   = r_err_count;
    assign bus.fail_valid  = r_fail_valid;
    assign bus.first_fail  = r_first_fail;

endmodule

// File: tb/tb_logicunit_bist.sv
// tb/tb_logicunit_bist.sv - directed self-checking bench for logicunit_bist
module tb_logicunit_bist;

    localparam int ERR_W = 5;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   mode  = 0;
    int   errors = 0;
    int   checks = 0;

    logicunit_bist_if #(.ERR_W(ERR_W)) bus ();

    logicunit_bist #(.ERR_W(ERR_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // mode 0: correct unit, 1: output stuck at 0, 2: opcode 3 computes XNOR
    function automatic logic unit_model(input logic a, input logic b,
                                        input logic [1:0] c, input int m);
        if (m == 1) return 1'b0;
        case (c)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return ~(a | b);
            default: return (m == 2) ? ~(a ^ b) : (a ^ b);
        endcase
    endfunction

    assign bus.dut_out = unit_model(bus.dut_a, bus.dut_b, bus.dut_control, mode);

    task automatic start_pulse();
        @(negedge clock);
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!bus.done && cycles < 40) begin
            @(posedge clock);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if ({bus.dut_a, bus.dut_b, bus.dut_control} !== 4'd0) begin errors++; $display("FAIL reset_dut: got %0d expected 0", {bus.dut_a, bus.dut_b, bus.dut_control}); end
        checks++; if ({bus.busy, bus.done, bus.pass, bus.fail_valid} !== 4'd0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {bus.busy, bus.done, bus.pass, bus.fail_valid}); end
        checks++; if (bus.err_count !== 5'd0) begin errors++; $display("FAIL reset_err: got %0d expected 0", bus.err_count); end
        checks++; if (bus.first_fail !== 4'd0) begin errors++; $display("FAIL reset_first: got %0d expected 0", bus.first_fail); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_good_pass();
        int cycles;
        mode = 0;
        start_pulse();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL good_busy: got %b expected 1", bus.busy); end
        checks++; if ({bus.dut_control, bus.dut_b, bus.dut_a} !== 4'd0) begin errors++; $display("FAIL good_vec0: got %0d expected 0", {bus.dut_control, bus.dut_b, bus.dut_a}); end
        @(posedge clock);
        #1;
        checks++; if ({bus.dut_control, bus.dut_b, bus.dut_a} !== 4'd1) begin errors++; $display("FAIL good_vec1: got %0d expected 1", {bus.dut_control, bus.dut_b, bus.dut_a}); end
        wait_done(cycles);
        cycles = cycles + 1;
        checks++; if (cycles !== 16) begin errors++; $display("FAIL good_latency: got %0d expected 16", cycles); end
        checks++; if ({bus.pass, bus.busy, bus.fail_valid} !== 3'b100) begin errors++; $display("FAIL good_status: got %b expected 100", {bus.pass, bus.busy, bus.fail_valid}); end
        checks++; if (bus.err_count !== 5'd0) begin errors++; $display("FAIL good_err: got %0d expected 0", bus.err_count); end
        repeat (3) @(posedge clock);
        #1;
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL good_done_hold: got %b expected 1", bus.done); end
        checks++; if ({bus.dut_control, bus.dut_b, bus.dut_a} !== 4'd15) begin errors++; $display("FAIL good_vec_hold: got %0d expected 15", {bus.dut_control, bus.dut_b, bus.dut_a}); end
    endtask

    task automatic test_stuck0();
        int cycles;
        mode = 1;
        start_pulse();
        checks++; if ({bus.done, bus.fail_valid, bus.err_count} !== {2'b00, 5'd0}) begin errors++; $display("FAIL stuck_clear: got done=%b fv=%b err=%0d expected 0 0 0", bus.done, bus.fail_valid, bus.err_count); end
        wait_done(cycles);
        checks++; if (cycles !== 16) begin errors++; $display("FAIL stuck_latency: got %0d expected 16", cycles); end
        checks++; if (bus.err_count !== 5'd7) begin errors++; $display("FAIL stuck_err: got %0d expected 7", bus.err_count); end
        checks++; if (bus.first_fail !== 4'd3) begin errors++; $display("FAIL stuck_first: got %0d expected 3", bus.first_fail); end
        checks++; if ({bus.pass, bus.fail_valid} !== 2'b01) begin errors++; $display("FAIL stuck_flags: got %b expected 01", {bus.pass, bus.fail_valid}); end
    endtask

    task automatic test_xnor();
        int cycles;
        mode = 2;
        start_pulse();
        wait_done(cycles);
        checks++; if (bus.err_count !== 5'd4) begin errors++; $display("FAIL xnor_err: got %0d expected 4", bus.err_count); end
        checks++; if (bus.first_fail !== 4'd12) begin errors++; $display("FAIL xnor_first: got %0d expected 12", bus.first_fail); end
        checks++; if (bus.pass !== 1'b0) begin errors++; $display("FAIL xnor_pass: got %b expected 0", bus.pass); end
    endtask

    task automatic test_reset_mid_pass();
        int cycles;
        mode = 1;
        start_pulse();
        repeat (8) @(posedge clock);
        #1;
        checks++; if (bus.err_count !== 5'd4) begin errors++; $display("FAIL midrst_pre_err: got %0d expected 4", bus.err_count); end
        checks++; if ({bus.dut_control, bus.dut_b, bus.dut_a} !== 4'd8) begin errors++; $display("FAIL midrst_pre_vec: got %0d expected 8", {bus.dut_control, bus.dut_b, bus.dut_a}); end
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        checks++; if ({bus.busy, bus.done, bus.pass, bus.fail_valid} !== 4'd0) begin errors++; $display("FAIL midrst_flags: got %b expected 0000", {bus.busy, bus.done, bus.pass, bus.fail_valid}); end
        checks++; if ({bus.err_count, bus.first_fail, bus.dut_control, bus.dut_b, bus.dut_a} !== 13'd0) begin errors++; $display("FAIL midrst_values: got err=%0d ff=%0d vec=%0d expected 0", bus.err_count, bus.first_fail, {bus.dut_control, bus.dut_b, bus.dut_a}); end
        mode = 0;
        start_pulse();
        wait_done(cycles);
        checks++; if (cycles !== 16) begin errors++; $display("FAIL midrst_latency: got %0d expected 16", cycles); end
        checks++; if ({bus.pass, bus.err_count} !== {1'b1, 5'd0}) begin errors++; $display("FAIL midrst_clean: got pass=%b err=%0d expected 1 0", bus.pass, bus.err_count); end
    endtask

    task automatic test_start_ignored();
        int cycles;
        mode = 0;
        start_pulse();
        cycles = 0;
        while (!bus.done && cycles < 40) begin
            @(posedge clock);
            #1;
            cycles++;
            if (cycles == 5) bus.start = 1'b1;
            if (cycles == 6) bus.start = 1'b0;
        end
        bus.start = 1'b0;
        checks++; if (cycles !== 16) begin errors++; $display("FAIL ignore_latency: got %0d expected 16", cycles); end
        checks++; if (bus.pass !== 1'b1) begin errors++; $display("FAIL ignore_pass: got %b expected 1", bus.pass); end
    endtask

    task automatic test_back_to_back();
        int cycles;
        mode = 1;
        @(negedge clock);
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        wait_done(cycles);
        checks++; if (cycles !== 16) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 16", cycles); end
        checks++; if (bus.err_count !== 5'd7) begin errors++; $display("FAIL b2b_first_err: got %0d expected 7", bus.err_count); end
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        checks++; if ({bus.busy, bus.done} !== 2'b10) begin errors++; $display("FAIL b2b_restart: got busy/done=%b expected 10", {bus.busy, bus.done}); end
        checks++; if ({bus.err_count, bus.fail_valid, bus.first_fail} !== 10'd0) begin errors++; $display("FAIL b2b_clear: got err=%0d fv=%b ff=%0d expected 0", bus.err_count, bus.fail_valid, bus.first_fail); end
        wait_done(cycles);
        checks++; if (cycles !== 16) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 16", cycles); end
        checks++; if ({bus.err_count, bus.first_fail} !== {5'd7, 4'd3}) begin errors++; $display("FAIL b2b_second: got err=%0d ff=%0d expected 7 3", bus.err_count, bus.first_fail); end
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_good_pass();
        test_stuck0();
        test_xnor();
        test_reset_mid_pass();
        test_start_ignored();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
